// File: rtl/hub75_fb_row_loader.sv
// hub75_fb_row_loader
//   Read-out side of the HUB75 framebuffer. On rd_row_load it fetches one
//   display row (all banks, all columns) from the shared framebuffer through
//   a req/gnt/rel arbiter handshake. Each pixel is split into three colour
//   channels, widened to 8 bits and cut to N_PLANES bit-planes, then written
//   into the back half of a double-buffered line buffer. The scan engine
//   reads the front half by column.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   rd_row_addr      row to preload (latched on rd_row_load)
//   rd_row_load      start-preload pulse, honoured only when idle
//   rd_row_rdy       high when idle
//   rd_row_swap      exchange front/back line buffers (idle only)
//   rd_data          planes of the addressed column, bank-major then channel
//   rd_col_addr      column to read
//   rd_en            read strobe; rd_data updates on the next cycle
//   ctrl_req         framebuffer access request
//   ctrl_gnt         grant pulse from the arbiter
//   ctrl_rel         release pulse, in the cycle the final word is captured
//   fb_addr          framebuffer address {bank,row,col,dc}
//   fb_data          framebuffer data, one cycle after fb_addr
module hub75_fb_row_loader #(
  parameter int unsigned N_BANKS  = 2,
  parameter int unsigned N_ROWS   = 32,
  parameter int unsigned N_COLS   = 64,
  parameter int unsigned N_CHANS  = 3,
  parameter int unsigned N_PLANES = 8,
  parameter int unsigned BITDEPTH = 16,
  parameter int unsigned FB_AW    = 12,
  parameter int unsigned FB_DW    = 16,
  parameter int unsigned FB_DC    = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [$clog2(N_ROWS)-1:0]             rd_row_addr,
  input  logic                                  rd_row_load,
  output logic                                  rd_row_rdy,
  input  logic                                  rd_row_swap,
  output logic [N_BANKS*N_CHANS*N_PLANES-1:0]   rd_data,
  input  logic [$clog2(N_COLS)-1:0]             rd_col_addr,
  input  logic                                  rd_en,
  output logic                                  ctrl_req,
  input  logic                                  ctrl_gnt,
  output logic                                  ctrl_rel,
  output logic [FB_AW-1:0]                      fb_addr,
  input  logic [FB_DW-1:0]                      fb_data
);

  localparam int unsigned RW     = $clog2(N_ROWS);
  localparam int unsigned COLW   = $clog2(N_COLS);
  localparam int unsigned BKW    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int unsigned LOW    = $clog2(N_COLS * FB_DC);
  localparam int unsigned NWORDS = N_BANKS * N_COLS * FB_DC;
  // One spare bit keeps the divisors below representable for any bank count.
  localparam int unsigned CNTW   = $clog2(NWORDS) + 1;
  localparam int unsigned BANKW  = N_CHANS * N_PLANES;

  localparam logic [CNTW-1:0] LAST   = CNTW'(NWORDS - 1);
  localparam logic [CNTW-1:0] LOMASK = CNTW'((1 << LOW) - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_READ, S_FLUSH} state_t;

  state_t          state;
  logic            front;
  logic [RW-1:0]   row;
  logic [CNTW-1:0] cnt;
  logic            d_vld;
  logic [CNTW-1:0] d_cnt;

  // Word counter is {bank,col,dc}; the row field is spliced in between.
  function automatic logic [FB_AW-1:0] word_addr(input logic [CNTW-1:0] c,
                                                 input logic [RW-1:0]   r);
    word_addr = (FB_AW'(c >> LOW) << (LOW + RW)) |
                (FB_AW'(r) << LOW) |
                FB_AW'(c & LOMASK);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_row_rdy <= 1'b1;
      ctrl_req   <= 1'b0;
      ctrl_rel   <= 1'b0;
      fb_addr    <= '0;
      front      <= 1'b0;
      row        <= '0;
      cnt        <= '0;
      d_vld      <= 1'b0;
      d_cnt      <= '0;
    end else begin
      ctrl_rel <= 1'b0;
      d_vld    <= 1'b0;
      case (state)
        S_IDLE: begin
          // Swap lands on the same edge as an accepted load, so the load
          // fills the buffer that just became the back one.
          if (rd_row_swap) front <= ~front;
          if (rd_row_load) begin
            row        <= rd_row_addr;
            rd_row_rdy <= 1'b0;
            ctrl_req   <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (ctrl_gnt) begin
            ctrl_req <= 1'b0;
            cnt      <= '0;
            fb_addr  <= word_addr('0, row);
            state    <= S_READ;
          end
        end
        S_READ: begin
          d_vld <= 1'b1;
          d_cnt <= cnt;
          if (cnt == LAST) begin
            ctrl_rel <= 1'b1;
            state    <= S_FLUSH;
          end else begin
            cnt     <= cnt + 1'b1;
            fb_addr <= word_addr(cnt + 1'b1, row);
          end
        end
        S_FLUSH: begin
          rd_row_rdy <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decode of the word whose data is on fb_data this cycle.
  logic [CNTW-1:0] d_dc;
  logic [COLW-1:0] d_col;
  logic [BKW-1:0]  d_bank;
  assign d_dc   = d_cnt % CNTW'(FB_DC);
  assign d_col  = COLW'(d_cnt / CNTW'(FB_DC));
  assign d_bank = BKW'(d_cnt / CNTW'(N_COLS * FB_DC));

  logic [FB_DW*FB_DC-1:0] pix_w;

  if (FB_DC > 1) begin : g_acc
    // Earlier words of the pixel; the final word is used straight off fb_data.
    logic [FB_DW*(FB_DC-1)-1:0] acc;
    always_ff @(posedge clk) begin
      if (d_vld) begin
        for (int unsigned k = 0; k < FB_DC - 1; k++) begin
          if (d_dc == CNTW'(k)) acc[k*FB_DW +: FB_DW] <= fb_data;
        end
      end
    end
    assign pix_w = {fb_data, acc};
  end else begin : g_noacc
    assign pix_w = fb_data;
  end

  logic unused_pix;
  assign unused_pix = ^pix_w;

  // Extract channel c and widen it to 8 bits by repeating its own MSBs.
  function automatic logic [7:0] chan_expand(input logic [23:0]   p,
                                             input int unsigned   c);
    int unsigned w;
    int unsigned lsb;
    logic [7:0]  v;
    case (BITDEPTH)
      24: begin
        w   = 8;
        lsb = 8 * c;
      end
      8: begin
        w   = (c == 2) ? 2 : 3;
        lsb = 3 * c;
      end
      default: begin
        w   = (c == 1) ? 6 : 5;
        lsb = (c == 0) ? 0 : ((c == 1) ? 5 : 11);
      end
    endcase
    v = 8'(p >> lsb);
    chan_expand = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      chan_expand[3'(7 - i)] = v[3'(w - 1 - (i % w))];
    end
  endfunction

  logic [23:0]      pix24;
  logic [BANKW-1:0] wr_val;
  assign pix24 = 24'(pix_w[BITDEPTH-1:0]);

  always_comb begin
    wr_val = '0;
    for (int unsigned c = 0; c < N_CHANS; c++) begin
      wr_val[c*N_PLANES +: N_PLANES] = N_PLANES'(chan_expand(pix24, c) >> (8 - N_PLANES));
    end
  end

  logic [BANKW-1:0] lb [2][N_BANKS][N_COLS];

  always_ff @(posedge clk) begin
    if (!rst && d_vld && d_dc == CNTW'(FB_DC - 1)) begin
      lb[~front][d_bank][d_col] <= wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int unsigned b = 0; b < N_BANKS; b++) begin
        rd_data[b*BANKW +: BANKW] <= lb[front][BKW'(b)][rd_col_addr];
      end
    end
  end

endmodule

// File: tb/tb_hub75_fb_row_loader.sv
// tb_hub75_fb_row_loader
//   Directed bench for hub75_fb_row_loader: one instance with default
//   parameters (RGB565, one word per pixel) and one with RGB888 stored as
//   two 16-bit words per pixel. Each has a small framebuffer model with
//   one-cycle read latency. Inputs are driven and outputs sampled 1 ns after
//   the rising edge.
module tb_hub75_fb_row_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [4:0]  row_addr;
  logic        row_load, row_rdy, row_swap;
  logic [47:0] rdata;
  logic [5:0]  col_addr;
  logic        ren, req, gnt, rel;
  logic [11:0] fa;
  logic [15:0] fd;

  logic [4:0]  x_row_addr;
  logic        x_row_load, x_row_rdy, x_row_swap;
  logic [47:0] x_rdata;
  logic [5:0]  x_col_addr;
  logic        x_ren, x_req, x_gnt, x_rel;
  logic [12:0] x_fa;
  logic [15:0] x_fd;

  logic [15:0] fb16 [4096];
  logic [15:0] fb24 [8192];

  always @(posedge clk) fd   <= fb16[fa];
  always @(posedge clk) x_fd <= fb24[x_fa];

  hub75_fb_row_loader dut (
    .clk(clk), .rst(rst),
    .rd_row_addr(row_addr), .rd_row_load(row_load), .rd_row_rdy(row_rdy),
    .rd_row_swap(row_swap), .rd_data(rdata), .rd_col_addr(col_addr),
    .rd_en(ren), .ctrl_req(req), .ctrl_gnt(gnt), .ctrl_rel(rel),
    .fb_addr(fa), .fb_data(fd)
  );

  hub75_fb_row_loader #(.BITDEPTH(24), .FB_AW(13), .FB_DC(2)) dut24 (
    .clk(clk), .rst(rst),
    .rd_row_addr(x_row_addr), .rd_row_load(x_row_load), .rd_row_rdy(x_row_rdy),
    .rd_row_swap(x_row_swap), .rd_data(x_rdata), .rd_col_addr(x_col_addr),
    .rd_en(x_ren), .ctrl_req(x_req), .ctrl_gnt(x_gnt), .ctrl_rel(x_rel),
    .fb_addr(x_fa), .fb_data(x_fd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Row-5 values, hand-derived:
  //   b0 c10 0xF800 -> ch2=0x1F -> FF ; b1 c10 0x07E0 -> ch1=0x3F -> FF
  //   b0 c0  0x0841 -> ch0=1,ch1=2,ch2=1 -> 08,08,08 ; b1 c63 0xFFFF -> all FF
  localparam logic [47:0] R5_C10 = 48'h00FF00_FF0000;
  localparam logic [47:0] R5_C0  = 48'h000000_080808;
  localparam logic [47:0] R5_C63 = 48'hFFFFFF_000000;
  // Row 9: b0 c10 0x001F -> ch0 FF ; b1 c10 0x8410 -> ch0 84, ch1 82, ch2 84
  localparam logic [47:0] R9_C10 = 48'h848284_0000FF;
  // Row 12: b0 c10 0x0841 -> 08,08,08 ; b1 c10 zero
  localparam logic [47:0] R12_C10 = 48'h000000_080808;

  task automatic load16(input logic [4:0] row, input int gw, input logic with_swap);
    row_addr = row;
    row_load = 1'b1;
    row_swap = with_swap;
    tick;
    row_load = 1'b0;
    row_swap = 1'b0;
    check("req_up", req, 1);
    check("rdy_busy", row_rdy, 0);
    for (int i = 0; i < gw; i++) begin
      tick;
      check("req_hold", req, 1);
    end
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    check("req_drop", req, 0);
    for (int i = 0; i < 128; i++) begin
      check("addr16", fa, ((i >> 6) << 11) | (row << 6) | (i & 63));
      check("rel_early", rel, 0);
      tick;
    end
    check("rel_pulse", rel, 1);
    check("rdy_flush", row_rdy, 0);
    tick;
    check("rel_end", rel, 0);
    check("rdy_back", row_rdy, 1);
  endtask

  task automatic rd(input logic [5:0] col, input logic [47:0] exp, input string tag);
    col_addr = col;
    ren      = 1'b1;
    tick;
    ren      = 1'b0;
    check(tag, rdata, exp);
  endtask

  // Reads front buffer while a load runs; optionally pokes swap/load mid-load.
  task automatic reader(input logic [47:0] e10, input logic [47:0] e63, input logic disturb);
    for (int k = 0; k < 40; k++) begin
      ren      = 1'b1;
      col_addr = k[0] ? 6'd63 : 6'd10;
      if (disturb && k == 20) begin
        row_swap = 1'b1;
        row_load = 1'b1;
        row_addr = 5'd3;
      end
      if (disturb && k == 21) begin
        row_swap = 1'b0;
        row_load = 1'b0;
      end
      tick;
      check("read_during_load", rdata, k[0] ? e63 : e10);
    end
    ren = 1'b0;
  endtask

  initial begin
    int rels;
    for (int i = 0; i < 4096; i++) fb16[i] = '0;
    for (int i = 0; i < 8192; i++) fb24[i] = '0;
    fb16[330]  = 16'hF800;  fb16[2378] = 16'h07E0;
    fb16[320]  = 16'h0841;  fb16[2431] = 16'hFFFF;
    fb16[586]  = 16'h001F;  fb16[2634] = 16'h8410;
    fb16[778]  = 16'h0841;
    // row 7, col 3: bank0 {0x0012,0x3456}, bank1 {0x00AB,0xCDEF}
    fb24[902]  = 16'h3456;  fb24[903]  = 16'h0012;
    fb24[4998] = 16'hCDEF;  fb24[4999] = 16'h00AB;

    rst = 1'b1;
    row_addr = '0; row_load = 1'b0; row_swap = 1'b0; col_addr = '0; ren = 1'b0; gnt = 1'b0;
    x_row_addr = '0; x_row_load = 1'b0; x_row_swap = 1'b0; x_col_addr = '0; x_ren = 1'b0; x_gnt = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("rst_rdy", row_rdy, 1);
    check("rst_req", req, 0);
    check("rst_rel", rel, 0);
    check("rst_addr", fa, 0);
    check("rst_data", rdata, 0);
    check("rst_rdy24", x_row_rdy, 1);

    // Row 5, grant three cycles after request
    load16(5'd5, 3, 1'b0);
    row_swap = 1'b1;
    tick;
    row_swap = 1'b0;
    check("rdy_after_swap", row_rdy, 1);
    rd(6'd10, R5_C10, "rowA_col10");
    rd(6'd0,  R5_C0,  "rowA_col0");
    rd(6'd63, R5_C63, "rowA_col63");

    // Load row 9 into the back buffer; mid-load swap/load must be ignored
    fork
      load16(5'd9, 2, 1'b0);
      begin tick; reader(R5_C10, R5_C63, 1'b1); end
    join
    check("hold_after_load", rdata, R5_C63);
    rd(6'd10, R5_C10, "rowA_before_swap");
    row_swap = 1'b1;
    tick;
    row_swap = 1'b0;
    rd(6'd10, R9_C10, "rowB_col10");
    rd(6'd63, 48'h0,  "rowB_col63");
    rd(6'd10, R9_C10, "rowB_col10_again");
    col_addr = 6'd63;
    repeat (2) tick;
    check("hold_en_low", rdata, R9_C10);

    // Swap together with load: the load fills the newly demoted buffer
    fork
      load16(5'd12, 0, 1'b1);
      begin tick; reader(R5_C10, R5_C63, 1'b0); end
    join
    row_swap = 1'b1;
    tick;
    row_swap = 1'b0;
    rd(6'd10, R12_C10, "rowC_col10");

    // RGB888 over two 16-bit words per pixel, row 7
    x_row_addr = 5'd7;
    x_row_load = 1'b1;
    tick;
    x_row_load = 1'b0;
    check("req24_up", x_req, 1);
    tick;
    x_gnt = 1'b1;
    tick;
    x_gnt = 1'b0;
    for (int i = 0; i < 256; i++) begin
      check("addr24", x_fa, ((i >> 7) << 12) | (7 << 7) | (i & 127));
      tick;
    end
    check("rel24_pulse", x_rel, 1);
    tick;
    check("rdy24_back", x_row_rdy, 1);
    x_row_swap = 1'b1;
    tick;
    x_row_swap = 1'b0;
    x_col_addr = 6'd3;
    x_ren = 1'b1;
    tick;
    check("px24_col3", x_rdata, 48'hABCDEF_123456);
    x_col_addr = 6'd4;
    tick;
    x_ren = 1'b0;
    check("px24_col4", x_rdata, 48'h0);

    // Reset in the middle of a load
    row_addr = 5'd5;
    row_load = 1'b1;
    tick;
    row_load = 1'b0;
    gnt = 1'b1;
    tick;
    gnt = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_rdy", row_rdy, 1);
    check("abort_req", req, 0);
    check("abort_rel", rel, 0);
    check("abort_addr", fa, 0);
    check("abort_data", rdata, 0);
    rels = 0;
    repeat (140) begin
      tick;
      if (rel) rels++;
    end
    check("abort_no_rel", rels, 0);
    check("abort_rdy_end", row_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
